// File: rtl/plb_lookup_stage.sv
// Purpose: PLB lookup stage. A fully-associative cache of MPT permission entries, searched by SPA page number and SDID, with a fill port for the walker.
// Latency: 1 cycle. The result is registered on m_* in the cycle after s_* is accepted. Fills become matchable in the cycle after the fill edge.
// Backpressure: single-entry output register without a skid buffer. s_ready_o drops while a result is held and m_ready_i is low, or while flush_i is high.
module plb_lookup_stage #(
    parameter int NUM_ENTRIES = 8,
    parameter int SPA_WIDTH   = 56,
    parameter int SDID_WIDTH  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [SPA_WIDTH-1:0]  s_spa_i,
    input  logic [SDID_WIDTH-1:0] s_sdid_i,
    input  logic [1:0]            s_access_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [SPA_WIDTH-1:0]  m_spa_o,
    output logic [SDID_WIDTH-1:0] m_sdid_o,
    output logic [1:0]            m_access_o,
    output logic                  m_hit_o,
    output logic                  m_allow_o,
    output logic [2:0]            m_perm_o,
    input  logic                  fill_valid_i,
    input  logic [SPA_WIDTH-13:0] fill_ppn_i,
    input  logic [SDID_WIDTH-1:0] fill_sdid_i,
    input  logic [2:0]            fill_perm_i
);

    localparam int PPN_W = SPA_WIDTH - 12;
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef struct packed {
        logic                  vld;
        logic [PPN_W-1:0]      ppn;
        logic [SDID_WIDTH-1:0] sdid;
        logic [2:0]            perm;   // {x,w,r}
    } plb_entry_t;

    plb_entry_t       ent_q [NUM_ENTRIES];
    logic [IDX_W-1:0] vptr_q;

    logic             s_accept;
    logic [PPN_W-1:0] s_ppn;
    logic             lk_hit;
    logic [2:0]       lk_perm;
    logic             lk_allow;

    logic             dup_hit;
    logic [IDX_W-1:0] dup_idx;
    logic             free_hit;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] fill_idx;
    logic             fill_evict;

    assign s_ready_o = !flush_i && (!m_valid_o || m_ready_i);
    assign s_accept  = s_valid_i && s_ready_o;
    assign s_ppn     = s_spa_i[SPA_WIDTH-1:12];

    // Search the pre-fill array. Fills never create duplicates, so the OR of matching perms equals the single match.
    always_comb begin
        lk_hit  = 1'b0;
        lk_perm = 3'b000;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_q[i].vld && ent_q[i].ppn == s_ppn && ent_q[i].sdid == s_sdid_i) begin
                lk_hit  = 1'b1;
                lk_perm = lk_perm | ent_q[i].perm;
            end
        end
    end

    // Select the permission bit for the access type. The reserved encoding never allows.
    always_comb begin
        lk_allow = 1'b0;
        case (s_access_i)
            2'b00:   lk_allow = lk_perm[0];
            2'b01:   lk_allow = lk_perm[1];
            2'b10:   lk_allow = lk_perm[2];
            default: lk_allow = 1'b0;
        endcase
        if (!lk_hit) begin
            lk_allow = 1'b0;
        end
    end

    // Pick the fill slot. Priority: the same key (update in place), then the lowest free slot, then the victim pointer.
    always_comb begin
        dup_hit  = 1'b0;
        dup_idx  = '0;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_q[i].vld && ent_q[i].ppn == fill_ppn_i && ent_q[i].sdid == fill_sdid_i) begin
                dup_hit = 1'b1;
                dup_idx = i[IDX_W-1:0];
            end
            if (!ent_q[i].vld && !free_hit) begin
                free_hit = 1'b1;
                free_idx = i[IDX_W-1:0];
            end
        end
        fill_evict = !dup_hit && !free_hit;
        if (dup_hit) begin
            fill_idx = dup_idx;
        end else if (free_hit) begin
            fill_idx = free_idx;
        end else begin
            fill_idx = vptr_q;
        end
    end

    // Entry array and victim pointer. Flush wins over fill. Only an eviction advances the pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            vptr_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i].vld <= 1'b0;
            end
            vptr_q <= '0;
        end else if (fill_valid_i) begin
            ent_q[fill_idx] <= '{vld: 1'b1, ppn: fill_ppn_i, sdid: fill_sdid_i, perm: fill_perm_i};
            if (fill_evict) begin
                vptr_q <= vptr_q + 1'b1;
            end
        end
    end

    // Output register. It captures on accept and holds while stalled, so later fills cannot change a held result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_valid_o  <= 1'b0;
            m_spa_o    <= '0;
            m_sdid_o   <= '0;
            m_access_o <= '0;
            m_hit_o    <= 1'b0;
            m_allow_o  <= 1'b0;
            m_perm_o   <= '0;
        end else if (flush_i) begin
            m_valid_o <= 1'b0;
        end else if (s_accept) begin
            m_valid_o  <= 1'b1;
            m_spa_o    <= s_spa_i;
            m_sdid_o   <= s_sdid_i;
            m_access_o <= s_access_i;
            m_hit_o    <= lk_hit;
            m_allow_o  <= lk_allow;
            m_perm_o   <= lk_perm;
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_plb_lookup_stage.sv
// Purpose: directed bench for plb_lookup_stage. It covers misses, hits, permissions, fill placement, backpressure and flush.
// Latency: results are checked 1 cycle after the accepting edge.
// Backpressure: m_ready_i is held low in the stall scenarios and high elsewhere.
module tb_plb_lookup_stage;

    localparam int SW = 56;
    localparam int DW = 6;
    localparam int PW = SW - 12;

    logic          clk_i        = 1'b0;
    logic          rst_ni       = 1'b0;
    logic          flush_i      = 1'b0;
    logic          s_valid_i    = 1'b0;
    logic          s_ready_o;
    logic [SW-1:0] s_spa_i      = '0;
    logic [DW-1:0] s_sdid_i     = '0;
    logic [1:0]    s_access_i   = '0;
    logic          m_valid_o;
    logic          m_ready_i    = 1'b1;
    logic [SW-1:0] m_spa_o;
    logic [DW-1:0] m_sdid_o;
    logic [1:0]    m_access_o;
    logic          m_hit_o;
    logic          m_allow_o;
    logic [2:0]    m_perm_o;
    logic          fill_valid_i = 1'b0;
    logic [PW-1:0] fill_ppn_i   = '0;
    logic [DW-1:0] fill_sdid_i  = '0;
    logic [2:0]    fill_perm_i  = '0;

    int checks = 0;
    int errors = 0;

    plb_lookup_stage #(.NUM_ENTRIES(8), .SPA_WIDTH(SW), .SDID_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_spa_i(s_spa_i),
        .s_sdid_i(s_sdid_i), .s_access_i(s_access_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_spa_o(m_spa_o),
        .m_sdid_o(m_sdid_o), .m_access_o(m_access_o), .m_hit_o(m_hit_o),
        .m_allow_o(m_allow_o), .m_perm_o(m_perm_o),
        .fill_valid_i(fill_valid_i), .fill_ppn_i(fill_ppn_i),
        .fill_sdid_i(fill_sdid_i), .fill_perm_i(fill_perm_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired (checks %0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one transaction for one cycle with the downstream ready.
    task automatic send(input logic [SW-1:0] spa, input logic [DW-1:0] sdid, input logic [1:0] acc);
        s_valid_i  = 1'b1;
        s_spa_i    = spa;
        s_sdid_i   = sdid;
        s_access_i = acc;
        m_ready_i  = 1'b1;
        step();
        s_valid_i  = 1'b0;
    endtask

    task automatic fill(input logic [PW-1:0] ppn, input logic [DW-1:0] sdid, input logic [2:0] perm);
        fill_valid_i = 1'b1;
        fill_ppn_i   = ppn;
        fill_sdid_i  = sdid;
        fill_perm_i  = perm;
        step();
        fill_valid_i = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({m_valid_o, m_spa_o, m_sdid_o, m_access_o, m_hit_o, m_allow_o, m_perm_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%0b spa=%h hit=%0b perm=%b exp all zero",
                     m_valid_o, m_spa_o, m_hit_o, m_perm_o);
        end
        checks++;
        if (s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %0b exp 1", s_ready_o);
        end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_cold_miss();
        send(56'h0000_1234_5678, 6'd3, 2'b00);
        checks++;
        if ({m_valid_o, m_hit_o, m_allow_o, m_perm_o} !== 6'b100000) begin
            errors++;
            $display("FAIL cold_miss got valid=%0b hit=%0b allow=%0b perm=%b exp 1/0/0/000",
                     m_valid_o, m_hit_o, m_allow_o, m_perm_o);
        end
        checks++;
        if (m_spa_o !== 56'h0000_1234_5678 || m_sdid_o !== 6'd3 || m_access_o !== 2'b00) begin
            errors++;
            $display("FAIL cold_passthru got spa=%h sdid=%0d acc=%b exp 12345678/3/00",
                     m_spa_o, m_sdid_o, m_access_o);
        end
        step();
        checks++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL cold_drain got valid=%0b exp 0", m_valid_o);
        end
    endtask

    // Four back-to-back lookups cover every access encoding, including reserved.
    task automatic test_hit_perm();
        logic [3:0] exp_allow;
        exp_allow = 4'b0011;   // bit k = allow for access k: read 1, write 1, exec 0, reserved 0
        fill(44'h12345, 6'd3, 3'b011);
        m_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_valid_i  = 1'b1;
            s_spa_i    = 56'h1234_5ABC;
            s_sdid_i   = 6'd3;
            s_access_i = k[1:0];
            step();
            checks++;
            if (m_valid_o !== 1'b1 || m_hit_o !== 1'b1 || m_perm_o !== 3'b011 ||
                m_allow_o !== exp_allow[k] || m_access_o !== k[1:0]) begin
                errors++;
                $display("FAIL hit_perm acc=%0d got valid=%0b hit=%0b perm=%b allow=%0b exp 1/1/011/%0b",
                         k, m_valid_o, m_hit_o, m_perm_o, m_allow_o, exp_allow[k]);
            end
        end
        s_valid_i = 1'b0;
        step();
    endtask

    task automatic test_sdid_update();
        send(56'h1234_5ABC, 6'd4, 2'b00);
        checks++;
        if (m_hit_o !== 1'b0 || m_perm_o !== 3'b000) begin
            errors++;
            $display("FAIL sdid_isolation got hit=%0b perm=%b exp 0/000", m_hit_o, m_perm_o);
        end
        fill(44'h12345, 6'd3, 3'b100);
        send(56'h1234_5ABC, 6'd3, 2'b10);
        checks++;
        if (m_hit_o !== 1'b1 || m_perm_o !== 3'b100 || m_allow_o !== 1'b1) begin
            errors++;
            $display("FAIL inplace_update got hit=%0b perm=%b allow=%0b exp 1/100/1",
                     m_hit_o, m_perm_o, m_allow_o);
        end
        // Seven more distinct keys fill the array exactly, with no eviction.
        for (int k = 0; k < 7; k++) fill(44'h100 + PW'(k), 6'd3, 3'b001);
        for (int k = 0; k < 7; k++) begin
            send({44'h100 + PW'(k), 12'h000}, 6'd3, 2'b00);
            checks++;
            if (m_hit_o !== 1'b1 || m_allow_o !== 1'b1) begin
                errors++;
                $display("FAIL full_no_evict ppn=%h got hit=%0b allow=%0b exp 1/1", 44'h100 + k, m_hit_o, m_allow_o);
            end
        end
        // The victim pointer is still 0, so the next new key evicts entry 0, which holds 0x12345.
        fill(44'h200, 6'd3, 3'b001);
        send(56'h1234_5000, 6'd3, 2'b00);
        checks++;
        if (m_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL vptr_zero_evict got hit=%0b exp 0", m_hit_o);
        end
        send(56'h0010_0000, 6'd3, 2'b00);
        checks++;
        if (m_hit_o !== 1'b1) begin
            errors++;
            $display("FAIL vptr_zero_keep got hit=%0b exp 1", m_hit_o);
        end
        send(56'h0020_0000, 6'd3, 2'b00);
        checks++;
        if (m_hit_o !== 1'b1) begin
            errors++;
            $display("FAIL vptr_zero_new got hit=%0b exp 1", m_hit_o);
        end
    endtask

    task automatic test_round_robin();
        do_flush();
        for (int k = 0; k < 10; k++) fill(PW'(k), 6'd0, 3'b111);
        for (int k = 0; k < 10; k++) begin
            send({PW'(k), 12'h000}, 6'd0, 2'b01);
            checks++;
            if (m_hit_o !== (k >= 2) || m_allow_o !== (k >= 2)) begin
                errors++;
                $display("FAIL round_robin ppn=%0d got hit=%0b allow=%0b exp %0b", k, m_hit_o, m_allow_o, k >= 2);
            end
        end
    endtask

    task automatic test_backpressure();
        m_ready_i = 1'b1;
        step();
        m_ready_i  = 1'b0;
        s_valid_i  = 1'b1;
        s_spa_i    = 56'h0005_5000;
        s_sdid_i   = 6'd1;
        s_access_i = 2'b00;
        step();
        checks++;
        if (m_valid_o !== 1'b1 || m_hit_o !== 1'b0 || s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_capture got valid=%0b hit=%0b ready=%0b exp 1/0/0", m_valid_o, m_hit_o, s_ready_o);
        end
        fill(44'h55, 6'd1, 3'b001);
        step();
        checks++;
        if (m_valid_o !== 1'b1 || m_hit_o !== 1'b0 || m_spa_o !== 56'h0005_5000 || s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_frozen got valid=%0b hit=%0b spa=%h ready=%0b exp 1/0/55000/0",
                     m_valid_o, m_hit_o, m_spa_o, s_ready_o);
        end
        m_ready_i = 1'b1;
        step();
        checks++;
        if (m_valid_o !== 1'b1 || m_hit_o !== 1'b1 || m_allow_o !== 1'b1 || m_perm_o !== 3'b001) begin
            errors++;
            $display("FAIL bp_resend got valid=%0b hit=%0b allow=%0b perm=%b exp 1/1/1/001",
                     m_valid_o, m_hit_o, m_allow_o, m_perm_o);
        end
        // A lookup in the same cycle as its fill sees the pre-fill array.
        s_spa_i      = 56'h0006_6000;
        s_access_i   = 2'b10;
        fill_valid_i = 1'b1;
        fill_ppn_i   = 44'h66;
        fill_sdid_i  = 6'd1;
        fill_perm_i  = 3'b100;
        step();
        fill_valid_i = 1'b0;
        checks++;
        if (m_hit_o !== 1'b0 || m_allow_o !== 1'b0 || m_perm_o !== 3'b000) begin
            errors++;
            $display("FAIL same_cycle_fill got hit=%0b allow=%0b perm=%b exp 0/0/000", m_hit_o, m_allow_o, m_perm_o);
        end
        step();
        checks++;
        if (m_hit_o !== 1'b1 || m_allow_o !== 1'b1 || m_perm_o !== 3'b100) begin
            errors++;
            $display("FAIL next_cycle_fill got hit=%0b allow=%0b perm=%b exp 1/1/100", m_hit_o, m_allow_o, m_perm_o);
        end
        s_valid_i = 1'b0;
        step();
    endtask

    task automatic test_flush();
        do_flush();
        for (int k = 0; k < 4; k++) fill(44'hA0 + PW'(k), 6'd2, 3'b001);
        m_ready_i  = 1'b0;
        s_valid_i  = 1'b1;
        s_spa_i    = 56'h000A_0000;
        s_sdid_i   = 6'd2;
        s_access_i = 2'b00;
        step();
        checks++;
        if (m_valid_o !== 1'b1 || m_hit_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup got valid=%0b hit=%0b exp 1/1", m_valid_o, m_hit_o);
        end
        flush_i      = 1'b1;
        fill_valid_i = 1'b1;
        fill_ppn_i   = 44'hB0;
        fill_sdid_i  = 6'd2;
        fill_perm_i  = 3'b111;
        m_ready_i    = 1'b1;
        #1;
        checks++;
        if (s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %0b exp 0", s_ready_o);
        end
        m_ready_i = 1'b0;
        step();
        flush_i      = 1'b0;
        fill_valid_i = 1'b0;
        s_valid_i    = 1'b0;
        checks++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop got valid=%0b exp 0", m_valid_o);
        end
        for (int k = 0; k < 5; k++) begin
            send({(k < 4) ? 44'hA0 + PW'(k) : 44'hB0, 12'h000}, 6'd2, 2'b00);
            checks++;
            if (m_hit_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_invalidate k=%0d got hit=%0b exp 0", k, m_hit_o);
            end
        end
        // After the flush the next eviction goes to entry 0.
        for (int k = 0; k < 9; k++) fill(44'hC0 + PW'(k), 6'd2, 3'b001);
        send(56'h000C_0000, 6'd2, 2'b00);
        checks++;
        if (m_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_vptr_evict got hit=%0b exp 0", m_hit_o);
        end
        send(56'h000C_1000, 6'd2, 2'b00);
        checks++;
        if (m_hit_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_vptr_keep got hit=%0b exp 1", m_hit_o);
        end
        send(56'h000C_8000, 6'd2, 2'b00);
        checks++;
        if (m_hit_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_vptr_new got hit=%0b exp 1", m_hit_o);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_perm();
        test_sdid_update();
        test_round_robin();
        test_backpressure();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
